// File: rtl/vga_pix_pkg.sv
// vga_pix_pkg: shared pixel types, RGB565 to 10-bit expansion and frame sizing helpers
package vga_pix_pkg;
  localparam int H_ACT_DEFAULT = 640;
  localparam int V_ACT_DEFAULT = 480;
  localparam int FRAME_PIXELS = H_ACT_DEFAULT * V_ACT_DEFAULT;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb10_t;
  typedef enum logic {FILL, HOLD} fetch_state_t;
  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction
  // Replicating the MSBs into the low bits maps full scale to 10'h3FF and zero to zero.
  function automatic rgb10_t expand565(input rgb565_t p);
    return '{r: {p.r, p.r}, g: {p.g, p.g[5:2]}, b: {p.b, p.b}};
  endfunction
endpackage

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo: first-word-fall-through synchronous FIFO with flush and occupancy count
module vga_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/vga_sram_pixel_reader.sv
// vga_sram_pixel_reader: prefetches RGB565 pixels from SRAM into a FIFO and serves 10-bit RGB per request.
// Optional VGA_TEST_PATTERN_EN adds i_pattern_sel for an internal 8-bar colour pattern.
module vga_sram_pixel_reader
  import vga_pix_pkg::*;
#(
  parameter int          H_ACT      = H_ACT_DEFAULT,
  parameter int          V_ACT      = V_ACT_DEFAULT,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [19:0] BASE_ADDR  = 20'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_request,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        i_pattern_sel,
`endif
  output logic [9:0]  o_red,
  output logic [9:0]  o_green,
  output logic [9:0]  o_blue,
  input  logic        i_sram_gnt,
  output logic [19:0] o_sram_addr,
  input  logic [15:0] i_sram_dq,
  output logic        o_sram_oe_n,
  output logic        o_sram_ce_n,
  output logic        o_underflow
);
  localparam int FRAME = frame_pixels(H_ACT, V_ACT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_nxt;
  logic [19:0] fetch_cnt, addr_q;
  logic epoch, s1_v, s1_ep, s2_v, s2_ep;
  logic [15:0] s2_d, head;
  logic [CW-1:0] count, inflight;
  logic [CW:0] occ;
  logic issue, push, pop, pattern, last_fetch;
  rgb10_t pix, bar;
`ifdef VGA_TEST_PATTERN_EN
  localparam int XW = $clog2(H_ACT);
  localparam int BAR_W = H_ACT / 8;
  logic [XW-1:0] x;
  logic [2:0] bar_idx;
  assign pattern = i_pattern_sel;
  assign bar_idx = 3'(x / XW'(BAR_W));
  assign bar = '{r: {10{~bar_idx[1]}}, g: {10{~bar_idx[2]}}, b: {10{~bar_idx[0]}}};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) x <= '0;
    else if (i_frame_start) x <= '0;
    else if (i_request) x <= (x == XW'(H_ACT - 1)) ? '0 : x + 1'b1;
`else
  assign pattern = 1'b0;
  assign bar = '0;
`endif
  // Only returns tagged with the current epoch count toward occupancy or reach the FIFO.
  assign inflight = CW'(s1_v && s1_ep == epoch) + CW'(s2_v && s2_ep == epoch);
  assign occ = {1'b0, count} + {1'b0, inflight};
  assign last_fetch = fetch_cnt == 20'(FRAME - 1);
  assign issue = i_rst_n && !i_frame_start && !pattern && state == FILL && i_sram_gnt &&
                 occ < (CW + 1)'(FIFO_DEPTH);
  assign push = s2_v && s2_ep == epoch && !i_frame_start;
  assign pop = i_request && !i_frame_start && !pattern && count != '0;
  assign o_sram_oe_n = !issue;
  assign o_sram_ce_n = !issue;
  assign o_sram_addr = issue ? BASE_ADDR + fetch_cnt : addr_q;
  assign o_red = pix.r;
  assign o_green = pix.g;
  assign o_blue = pix.b;
  always_comb begin
    state_nxt = state;
    if (i_frame_start) state_nxt = FILL;
    else if (issue && last_fetch) state_nxt = HOLD;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= FILL;
      fetch_cnt <= '0;
      addr_q    <= BASE_ADDR;
      epoch     <= 1'b0;
      s1_v      <= 1'b0;
      s1_ep     <= 1'b0;
      s2_v      <= 1'b0;
      s2_ep     <= 1'b0;
      s2_d      <= '0;
    end else begin
      state <= state_nxt;
      s1_v  <= issue;
      s1_ep <= epoch;
      s2_v  <= s1_v;
      s2_ep <= s1_ep;
      s2_d  <= i_sram_dq;
      if (i_frame_start) begin
        fetch_cnt <= '0;
        epoch     <= !epoch;
      end else if (issue) begin
        fetch_cnt <= fetch_cnt + 20'd1;
        addr_q    <= o_sram_addr;
      end
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pix         <= '0;
      o_underflow <= 1'b0;
    end else if (i_frame_start) o_underflow <= 1'b0;
    else if (i_request) begin
      if (pattern) pix <= bar;
      else if (count != '0) pix <= expand565(rgb565_t'(head));
      else begin
        pix         <= '0;
        o_underflow <= 1'b1;
      end
    end
  vga_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_frame_start),
    .push  (push),
    .pop   (pop),
    .din   (s2_d),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_vga_sram_pixel_reader.sv
// tb_vga_sram_pixel_reader: directed sequences plus randomized traffic against a queue-based reference model
module tb_vga_sram_pixel_reader;
  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 16;
  localparam int FRAME = H * V;
  localparam logic [19:0] BASE = 20'h100;
  typedef struct {
    int          ready;
    logic [15:0] d;
  } ent_t;
  typedef struct {
    logic [15:0] d;
    logic [9:0]  r, g, b;
  } exp_vec_t;
  logic clk = 1'b0, rst_n, fs, req, gnt, psel;
  logic [15:0] dq;
  logic [9:0] o_red, o_green, o_blue;
  logic [19:0] addr;
  logic oe_n, ce_n, uflow;
  int vecs = 0, errs = 0, cyc = 0, nreads = 0, k = 0, xcnt = 0;
  ent_t q[$];
  logic [15:0] mem [FRAME];
  logic [9:0] er, eg, eb;
  logic euf, prev_iss;
  logic [15:0] prev_d;
  logic [19:0] eaddr;
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  exp_vec_t tbl [6];

  vga_sram_pixel_reader #(.H_ACT(H), .V_ACT(V), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_request(req),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern_sel(psel),
`endif
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .i_sram_gnt(gnt), .o_sram_addr(addr),
    .i_sram_dq(dq), .o_sram_oe_n(oe_n), .o_sram_ce_n(ce_n), .o_underflow(uflow)
  );

  always #20 clk = ~clk;

  function automatic logic [29:0] exp565(input logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]);
    g = int'(d[10:5]);
    b = int'(d[4:0]);
    return {10'(r * 33), 10'(g * 16 + g / 4), 10'(b * 33)};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fs = 1'b0; req = 1'b0; gnt = 1'b1; psel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_oe_n", oe_n, 1);
    cmp("rst_ce_n", ce_n, 1);
    cmp("rst_addr", addr, BASE);
    cmp("rst_rgb", {o_red, o_green, o_blue}, 0);
    cmp("rst_uflow", uflow, 0);
    gnt = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete(); k = 0; xcnt = 0; er = '0; eg = '0; eb = '0; euf = 1'b0;
    prev_iss = 1'b0; eaddr = BASE;
  endtask

  task automatic step(input logic f, input logic r, input logic g);
    logic iss;
    ent_t e;
    logic [2:0] c;
    @(posedge clk);
    #1;
    cyc++;
    dq = prev_iss ? prev_d : 16'($urandom);
    fs = f; req = r; gnt = g;
    @(negedge clk);
    cmp("rgb", {o_red, o_green, o_blue}, {er, eg, eb});
    cmp("uflow", uflow, euf);
    iss = g && !f && !psel && k < FRAME && q.size() < D;
    cmp("oe_n", oe_n, !iss);
    cmp("ce_n", ce_n, !iss);
    cmp("addr", addr, iss ? BASE + 20'(k) : eaddr);
    if (!oe_n) nreads++;
    prev_iss = iss;
    if (f) begin
      q.delete(); k = 0; euf = 1'b0; xcnt = 0;
    end else begin
      if (r) begin
        if (psel) begin
          c = bars[xcnt / (H / 8)];
          er = {10{c[2]}}; eg = {10{c[1]}}; eb = {10{c[0]}};
        end else if (q.size() > 0 && q[0].ready <= cyc) begin
          {er, eg, eb} = exp565(q[0].d);
          void'(q.pop_front());
        end else begin
          er = '0; eg = '0; eb = '0; euf = 1'b1;
        end
        xcnt = (xcnt + 1) % H;
      end
      if (iss) begin
        e.ready = cyc + 3;
        e.d = mem[k];
        q.push_back(e);
        prev_d = mem[k];
        eaddr = BASE + 20'(k);
        k++;
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'hF800, 10'h3FF, 10'h000, 10'h000};
    tbl[1] = '{16'h07E0, 10'h000, 10'h3FF, 10'h000};
    tbl[2] = '{16'h001F, 10'h000, 10'h000, 10'h3FF};
    tbl[3] = '{16'hFFFF, 10'h3FF, 10'h3FF, 10'h3FF};
    tbl[4] = '{16'h0000, 10'h000, 10'h000, 10'h000};
    tbl[5] = '{16'h8410, 10'h210, 10'h208, 10'h210};
    for (int i = 0; i < FRAME; i++) mem[i] = 16'(i);
    dq = '0; prev_d = '0;
    do_reset();
    // Prefetch stops at FIFO depth with no consumer.
    nreads = 0;
    repeat (24) step(0, 0, 1);
    cmp("fill_reads", nreads, D);
    // Continuous consumption streams words 0..FRAME-1 without a gap.
    repeat (FRAME) step(0, 1, 1);
    step(0, 0, 1);
    cmp("stream_uflow", uflow, 0);
    cmp("stream_last", {o_red, o_green, o_blue}, {10'h000, 10'h000, 10'h3FF});
    // Whole frame fetched: no further reads until the next frame start.
    repeat (8) step(0, 0, 1);
    cmp("hold_reads", nreads, FRAME);
    step(1, 0, 1);
    step(0, 0, 1);
    cmp("restart_addr", addr, BASE);
    cmp("restart_oe_n", oe_n, 0);
    // Request on an empty FIFO from reset.
    do_reset();
    step(0, 1, 0);
    step(0, 0, 0);
    cmp("empty_uflow", uflow, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    cmp("fs_clears_uflow", uflow, 0);
    // Frame start with two reads in flight discards their data.
    mem[0] = 16'h07E0; mem[1] = 16'h001F;
    step(0, 0, 1);
    step(0, 0, 1);
    mem[0] = 16'hF800;
    step(1, 0, 0);
    repeat (4) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    cmp("stale_discard", {o_red, o_green, o_blue}, {10'h3FF, 10'h000, 10'h000});
    // Expansion table.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      mem[0] = tbl[i].d;
      repeat (4) step(0, 0, 1);
      step(0, 1, 0);
      step(0, 0, 0);
      cmp("expand", {o_red, o_green, o_blue}, {tbl[i].r, tbl[i].g, tbl[i].b});
    end
`ifdef VGA_TEST_PATTERN_EN
    begin
      int n0;
      psel = 1'b1;
      step(1, 0, 1);
      n0 = nreads;
      repeat (2 * H) step(0, 1, 1);
      step(0, 0, 1);
      cmp("pattern_no_reads", nreads, n0);
      psel = 1'b0;
    end
`endif
    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < FRAME; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 75);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
